qdecode_ctrl: RTL and testbench
===============================

// Module: qdecode_ctrl
// PURPOSE
//   Controller in front of the quadrature encoder path. Synchronises and
//   glitch-filters the raw A/B pins and sequences the 4-state quadrature FSM.
//   Maintains a wrap or saturate position counter with enable/clear control.
//   Queues per-step direction events for a downstream consumer
//   (LED/UI logic) over a valid/ready handshake. Sits between top-level
//   encoder pins and display logic, one clock domain (PLL clk).
// PARAMETERS
//   WIDTH      4   position counter width (bits)
//   FILTER_LEN 16  consecutive stable cycles before a pin change is accepted (>=1)
//   FILTER_W   5   filter counter width; must hold FILTER_LEN
//   WRAP       1   1 = position wraps modulo 2^WIDTH, 0 = saturates at 0 / 2^WIDTH-1
//   QDEPTH     4   event queue depth (power of 2, >=2)
// PORTS
//   clk          in   1      system clock, all logic on rising edge
//   reset        in   1      synchronous, active-high reset
//   enc_a        in   1      raw encoder channel A (asynchronous)
//   enc_b        in   1      raw encoder channel B (asynchronous)
//   enable       in   1      1 = count steps and emit events
//   clear        in   1      1-cycle pulse: zero position
//   err_clear    in   1      1-cycle pulse: clear sticky error flags
//   position     out  WIDTH  current position
//   evt_valid    out  1      event queue non-empty
//   evt_dir      out  1      head event direction, 1 = up (+1), 0 = down (-1)
//   evt_ready    in   1      consumer accepts head event when evt_valid=1
//   evt_overflow out  1      sticky: an event was dropped (queue full)
//   err_illegal  out  1      sticky: A and B changed in the same filtered cycle
// BEHAVIOUR
//   Reset: all sync/filter flops, filtered A/B, previous-state reg, position,
//     queue pointers, evt_valid, evt_dir, evt_overflow, err_illegal = 0.
//   Sync: 2-flop synchroniser per channel.
//   Filter: per channel; counter increments while sync out != filtered value.
//     It resets to 0 on agreement. When counter = FILTER_LEN-1 and inputs still
//     differ, the filtered value takes the sync value next edge and the counter
//     returns to 0. Raw-to-filtered latency = 2 + FILTER_LEN cycles.
//   FSM: state = {A,B} filtered, previous state registered every cycle.
//     Up sequence 00->01->11->10->00 => +1 per transition; reverse => -1.
//     No change => nothing.
//     Both bits change => no step, err_illegal set; previous state still updated.
//   Step qualifies only if enable=1; previous state tracks regardless of enable.
//   Position updates 1 cycle after filtered change. WRAP=1: modulo 2^WIDTH.
//     WRAP=0: clamp at 0/max; a clamped step still generates an event.
//   clear: position <= 0 next cycle; overrides a simultaneous step; queue untouched.
//   Queue: FIFO of evt_dir bits. Push on qualified step, pop on evt_valid&&evt_ready.
//     Event visible on evt_valid same cycle position changes (queue was empty).
//     evt_dir is head entry; stable while evt_valid && !evt_ready.
//     Full + push + pop same cycle: both occur, no overflow.
//     Full + push, no pop: event dropped, evt_overflow set.
//     Empty + pop attempt: ignored.
//   err_clear clears evt_overflow/err_illegal; a set event in the same cycle wins.
//   Reset mid-operation: everything returns to reset values next edge, queue
//     emptied; a filtered state != 00 after reset is seen as a transition
//     from 00 (may count or flag illegal), by design.
// TESTING
//   Reset, A=B=0 idle 100 cycles -> position=0, evt_valid=0, both flags 0.
//   FILTER_LEN=16, enable=1, 4 clean up steps (each held 40 cycles), evt_ready=1 ->
//     position 0->4, four events dir=1, each 19 cycles after its pin edge.
//   Glitch: A pulses high 10 cycles (< FILTER_LEN) -> position, events unchanged.
//   WIDTH=4 WRAP=1: from 15, one up step -> 0; WRAP=0: from 15 up -> 15, event dir=1.
//   evt_ready=0, 5 down steps, QDEPTH=4 -> 4 queued dir=0, evt_overflow=1;
//     then ready=1 drains exactly 4; err_clear -> overflow 0.
//   Force A,B 00->11 in one filtered cycle -> err_illegal=1, position unchanged;
//     clear on same cycle as an up step -> position=0.

Source files
------------

// File: rtl/qdecode_ctrl.sv
// Quadrature encoder front end: synchronises and glitch-filters the raw A/B
// pins, decodes the 4-state quadrature sequence into up/down steps, keeps a
// wrapping or saturating position counter and queues per-step direction
// events for a downstream consumer over a valid/ready handshake.
module qdecode_ctrl #(
  parameter int WIDTH      = 4,
  parameter int FILTER_LEN = 16,
  parameter int FILTER_W   = 5,
  parameter int WRAP       = 1,
  parameter int QDEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enable,
  input  logic             clear,
  input  logic             err_clear,
  output logic [WIDTH-1:0] position,
  output logic             evt_valid,
  output logic             evt_dir,
  input  logic             evt_ready,
  output logic             evt_overflow,
  output logic             err_illegal
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [FILTER_W-1:0] FCNT_LAST = FILTER_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0]    QFULL     = CNT_W'(QDEPTH);

  // Position along the up sequence 00 -> 01 -> 11 -> 10 (Gray to binary).
  function automatic logic [1:0] quad_idx(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  // One position step, either modulo 2^WIDTH or clamped at 0 / max.
  function automatic logic [WIDTH-1:0] step_pos(input logic [WIDTH-1:0] p,
                                                input logic             up);
    logic [WIDTH-1:0] r;
    if (up) begin
      if (WRAP == 0 && p == '1) r = p;
      else                      r = p + 1'b1;
    end else begin
      if (WRAP == 0 && p == '0) r = p;
      else                      r = p - 1'b1;
    end
    return r;
  endfunction

  // Bit 1 carries channel A, bit 0 channel B throughout.
  logic [1:0]                sync1_q, sync1_d;
  logic [1:0]                sync2_q, sync2_d;
  logic [1:0]                filt_q, filt_d;
  logic [1:0][FILTER_W-1:0]  fcnt_q, fcnt_d;
  logic [1:0]                prev_q, prev_d;
  logic [WIDTH-1:0]          pos_q, pos_d;
  logic [QDEPTH-1:0]         mem_q, mem_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          qcnt_q, qcnt_d;
  logic                      ovf_q, ovf_d;
  logic                      ill_q, ill_d;

  logic [1:0] idx_diff;
  logic       step_up;
  logic       step_dn;
  logic       illegal_chg;
  logic       step_qual;
  logic       q_full;
  logic       q_empty;
  logic       pop;
  logic       push_ok;
  logic       drop;

  // Two-flop synchroniser next values for both channels.
  always_comb begin
    sync1_d = {enc_a, enc_b};
    sync2_d = sync1_q;
  end

  // Synchroniser registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Per-channel stability filter: accept a new level only after it has
  // disagreed with the filtered value for FILTER_LEN consecutive cycles.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync2_q[ch] != filt_q[ch]) begin
        if (fcnt_q[ch] == FCNT_LAST) begin
          filt_d[ch] = sync2_q[ch];
        end else begin
          fcnt_d[ch] = fcnt_q[ch] + 1'b1;
        end
      end
    end
  end

  // Filter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Quadrature FSM state register: the previously seen filtered {A,B}.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Quadrature FSM next state: always follows the filtered pins, even when
  // counting is disabled or the change was illegal.
  always_comb begin
    prev_d = filt_q;
  end

  // Quadrature FSM outputs: classify the transition prev -> current.
  always_comb begin
    idx_diff    = quad_idx(filt_q) - quad_idx(prev_q);
    step_up     = (idx_diff == 2'd1);
    step_dn     = (idx_diff == 2'd3);
    illegal_chg = (idx_diff == 2'd2);
    step_qual   = enable & (step_up | step_dn);
  end

  // Position counter: clear has priority over a coincident step.
  always_comb begin
    pos_d = pos_q;
    if (clear) begin
      pos_d = '0;
    end else if (step_qual) begin
      pos_d = step_pos(pos_q, step_up);
    end
  end

  // Event queue control: a push into a full queue still succeeds when the
  // head is popped in the same cycle; otherwise the event is dropped.
  always_comb begin
    q_full   = (qcnt_q == QFULL);
    q_empty  = (qcnt_q == '0);
    pop      = evt_ready & ~q_empty;
    push_ok  = step_qual & (~q_full | pop);
    drop     = step_qual & q_full & ~pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    qcnt_d   = qcnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = step_up;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   qcnt_d = qcnt_q + 1'b1;
      2'b01:   qcnt_d = qcnt_q - 1'b1;
      default: qcnt_d = qcnt_q;
    endcase
  end

  // Sticky error flags: a new set event wins over err_clear.
  always_comb begin
    ovf_d = ovf_q;
    ill_d = ill_q;
    if (err_clear) begin
      ovf_d = 1'b0;
      ill_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (illegal_chg) begin
      ill_d = 1'b1;
    end
  end

  // Position, queue and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q    <= '0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      qcnt_q   <= '0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      qcnt_q   <= qcnt_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

  // Head entry is forced low while the queue is empty.
  always_comb begin
    position     = pos_q;
    evt_valid    = ~q_empty;
    evt_dir      = ~q_empty & mem_q[rd_ptr_q];
    evt_overflow = ovf_q;
    err_illegal  = ill_q;
  end

endmodule

// File: tb/tb_qdecode_ctrl.sv
// Scoreboard bench for qdecode_ctrl: one wrapping and one saturating
// instance driven by the same pins; a quadrature reference model predicts
// positions, flags and the event stream.
module tb_qdecode_ctrl;

  localparam int WIDTH = 4;
  localparam int FL    = 16;
  localparam int FW    = 5;
  localparam int QD    = 4;
  localparam int HOLD  = 40;
  localparam int PMAX  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic reset, enc_a, enc_b, enable, clear, err_clear, evt_ready;
  logic [WIDTH-1:0] pos_w, pos_s;
  logic vld_w, dir_w, ovf_w, ill_w;
  logic vld_s, dir_s, ovf_s, ill_s;

  always #5 clk = ~clk;

  qdecode_ctrl #(.WIDTH(WIDTH), .FILTER_LEN(FL), .FILTER_W(FW), .WRAP(1), .QDEPTH(QD)) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enable(enable),
    .clear(clear), .err_clear(err_clear), .position(pos_w), .evt_valid(vld_w),
    .evt_dir(dir_w), .evt_ready(evt_ready), .evt_overflow(ovf_w), .err_illegal(ill_w));

  qdecode_ctrl #(.WIDTH(WIDTH), .FILTER_LEN(FL), .FILTER_W(FW), .WRAP(0), .QDEPTH(QD)) dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enable(enable),
    .clear(clear), .err_clear(err_clear), .position(pos_s), .evt_valid(vld_s),
    .evt_dir(dir_s), .evt_ready(evt_ready), .evt_overflow(ovf_s), .err_illegal(ill_s));

  int total = 0;
  int bad   = 0;
  bit exp_w[$];
  bit exp_s[$];
  int m_pos_w, m_pos_s;
  bit m_ovf, m_ill;
  logic [1:0] m_st;
  bit rdy_rand;
  int pops_w, pops_s;
  logic [1:0] up_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int seq_pos(input logic [1:0] s);
    for (int i = 0; i < 4; i++) if (up_seq[i] == s) return i;
    return 0;
  endfunction

  function automatic logic [1:0] nxt(input bit up);
    return up_seq[(seq_pos(m_st) + (up ? 1 : 3)) % 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) evt_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reference model of one accepted pin change.
  task automatic model_step(input logic [1:0] ns, input bit en);
    int d;
    bit up;
    d = (seq_pos(ns) - seq_pos(m_st) + 4) % 4;
    if (d == 2) begin
      m_ill = 1'b1;
    end else if (d != 0 && en) begin
      up = (d == 1);
      m_pos_w = (m_pos_w + (up ? 1 : PMAX)) % (PMAX + 1);
      if (up) begin
        if (m_pos_s < PMAX) m_pos_s++;
      end else begin
        if (m_pos_s > 0) m_pos_s--;
      end
      if (exp_w.size() < QD) begin
        exp_w.push_back(up);
        exp_s.push_back(up);
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_st = ns;
  endtask

  task automatic drive(input logic [1:0] ns, input bit en);
    {enc_a, enc_b} = ns;
    enable = en;
    model_step(ns, en);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".pos_wrap"}, int'(pos_w), m_pos_w);
    chk({tag, ".pos_sat"},  int'(pos_s), m_pos_s);
    chk({tag, ".ovf_wrap"}, int'(ovf_w), int'(m_ovf));
    chk({tag, ".ovf_sat"},  int'(ovf_s), int'(m_ovf));
    chk({tag, ".ill_wrap"}, int'(ill_w), int'(m_ill));
    chk({tag, ".ill_sat"},  int'(ill_s), int'(m_ill));
  endtask

  task automatic step(input logic [1:0] ns, input bit en, input string tag);
    drive(ns, en);
    ticks(HOLD);
    check_state(tag);
  endtask

  task automatic timed_up(input string tag);
    int old_w;
    old_w = m_pos_w;
    drive(nxt(1'b1), 1'b1);
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 18) begin
        chk({tag, ".pos_early"}, int'(pos_w), old_w);
        chk({tag, ".vld_early"}, int'(vld_w), 0);
      end
      if (k == 19) begin
        chk({tag, ".pos_on_time"}, int'(pos_w), m_pos_w);
        chk({tag, ".vld_on_time"}, int'(vld_w), 1);
        chk({tag, ".dir_on_time"}, int'(dir_w), 1);
      end
    end
    ticks(HOLD - 19);
    check_state(tag);
  endtask

  task automatic glitch(input bit on_a, input int len);
    if (on_a) enc_a = ~enc_a; else enc_b = ~enc_b;
    ticks(len);
    {enc_a, enc_b} = m_st;
    ticks(30);
    check_state("glitch");
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_pos_w = 0;
    m_pos_s = 0;
    tick();
    check_state("clear");
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    m_ovf = 1'b0;
    m_ill = 1'b0;
    tick();
    check_state("err_clear");
  endtask

  // Monitor: compare the head event against the scoreboard and retire it
  // when the consumer accepts it.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (vld_w) begin
        chk("evt_expected_wrap", (exp_w.size() > 0) ? 1 : 0, 1);
        if (exp_w.size() > 0) begin
          chk("evt_dir_wrap", int'(dir_w), int'(exp_w[0]));
          if (evt_ready) begin
            void'(exp_w.pop_front());
            pops_w++;
          end
        end
      end
      if (vld_s) begin
        chk("evt_expected_sat", (exp_s.size() > 0) ? 1 : 0, 1);
        if (exp_s.size() > 0) begin
          chk("evt_dir_sat", int'(dir_s), int'(exp_s[0]));
          if (evt_ready) begin
            void'(exp_s.pop_front());
            pops_s++;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enable = 1'b0;
    clear = 1'b0; err_clear = 1'b0; evt_ready = 1'b1; rdy_rand = 1'b0;
    m_pos_w = 0; m_pos_s = 0; m_ovf = 1'b0; m_ill = 1'b0; m_st = 2'b00;
    pops_w = 0; pops_s = 0;
    ticks(3);
    reset = 1'b0;

    // Idle after reset.
    ticks(100);
    check_state("idle");
    chk("idle.vld_wrap", int'(vld_w), 0);
    chk("idle.vld_sat",  int'(vld_s), 0);

    // Four clean up steps with latency checks.
    for (int i = 0; i < 4; i++) timed_up("up_lat");

    // Short glitch on A must be rejected.
    glitch(1'b1, 10);

    // Randomized mix of steps, glitches, clears and illegal changes.
    rdy_rand = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      step(nxt(1'($urandom_range(0, 1))), ($urandom_range(0, 4) != 0), "rnd_step");
      else if (r == 6) glitch(1'($urandom_range(0, 1)), $urandom_range(1, 12));
      else if (r == 7) pulse_clear();
      else if (r == 8) step(~m_st, 1'b1, "rnd_illegal");
      else             pulse_err_clear();
    end

    // Wrap versus saturate at the top and bottom of the range.
    pulse_clear();
    for (int i = 0; i < PMAX; i++) step(nxt(1'b1), 1'b1, "to_max");
    step(nxt(1'b1), 1'b1, "over_max");
    pulse_clear();
    step(nxt(1'b0), 1'b1, "under_zero");

    // Illegal double change from 00 to 11.
    rdy_rand = 1'b0;
    evt_ready = 1'b1;
    while (m_st != 2'b00) step(nxt(1'b1), 1'b1, "to_00");
    pulse_err_clear();
    step(2'b11, 1'b1, "illegal_00_11");
    pulse_err_clear();

    // Clear coinciding with an up step.
    drive(nxt(1'b1), 1'b1);
    ticks(18);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_pos_w = 0;
    m_pos_s = 0;
    ticks(HOLD - 19);
    check_state("clear_with_step");

    // Overflow: five down steps into a stalled queue of four.
    ticks(5);
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(nxt(1'b0), 1'b1, "ovf_fill");
    chk("ovf.vld_wrap", int'(vld_w), 1);
    chk("ovf.vld_sat",  int'(vld_s), 1);
    pops_w = 0;
    pops_s = 0;
    evt_ready = 1'b1;
    ticks(10);
    @(negedge clk);
    chk("drain.count_wrap", pops_w, 4);
    chk("drain.count_sat",  pops_s, 4);
    chk("drain.vld_wrap", int'(vld_w), 0);
    chk("drain.vld_sat",  int'(vld_s), 0);
    pulse_err_clear();

    // Reset while an event is pending and position is non-zero.
    step(nxt(1'b1), 1'b1, "pre_reset");
    evt_ready = 1'b0;
    step(nxt(1'b1), 1'b1, "pre_reset_q");
    reset = 1'b1;
    {enc_a, enc_b} = 2'b00;
    exp_w.delete();
    exp_s.delete();
    ticks(3);
    reset = 1'b0;
    m_pos_w = 0; m_pos_s = 0; m_ovf = 1'b0; m_ill = 1'b0; m_st = 2'b00;
    evt_ready = 1'b1;
    ticks(30);
    check_state("after_reset");
    chk("after_reset.vld_wrap", int'(vld_w), 0);
    chk("after_reset.vld_sat",  int'(vld_s), 0);

    // Every predicted event must have been delivered.
    step(nxt(1'b1), 1'b1, "final_step");
    ticks(20);
    @(negedge clk);
    chk("sb_empty_wrap", exp_w.size(), 0);
    chk("sb_empty_sat",  exp_s.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
